hazard_ctrl: RTL and testbench

//  Parametrised stall/forward controller for the 5-stage pipeline; supersedes the combinational stall logic.

---
 rtl/hazard_ctrl_pkg.sv | 8 +
 rtl/hazard_fwd_sel.sv | 21 ++
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: forwarding-select encodings shared by the hazard unit and the datapath muxes.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: picks the EX operand source for one register; MEM beats WB, loads never forward from MEM.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src_i,
  input  logic [RA_W-1:0] wr_mem_i,
  input  logic            reg_write_mem_i,
  input  logic            mem_to_reg_mem_i,
  input  logic [RA_W-1:0] wr_wb_i,
  input  logic            reg_write_wb_i,
  output logic [1:0]      sel_o
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = reg_write_mem_i & ~mem_to_reg_mem_i & (|src_i) & (src_i == wr_mem_i);
    wb_hit  = reg_write_wb_i & (|src_i) & (src_i == wr_wb_i);
    sel_o   = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze and forwarding control for the 5-stage pipeline,
// with a mul/div busy tracker and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  rs_ID,
  input  logic [RA_W-1:0]  rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             branch_ID,
  input  logic             hilo_rd_ID,
  input  logic             muldiv_ID,
  input  logic [RA_W-1:0]  rs_EX,
  input  logic [RA_W-1:0]  rt_EX,
  input  logic [RA_W-1:0]  writeReg_EX,
  input  logic             regWrite_EX,
  input  logic             memToReg_EX,
  input  logic             muldiv_EX,
  input  logic [RA_W-1:0]  writeReg_MEM,
  input  logic             regWrite_MEM,
  input  logic             memToReg_MEM,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  input  logic [RA_W-1:0]  writeReg_WB,
  input  logic             regWrite_WB,
  input  logic             perf_clr,
  output logic             IF_ID_stall,
  output logic             ID_EX_flush,
  output logic             pipe_freeze,
  output logic [1:0]       fwdA_EX,
  output logic [1:0]       fwdB_EX,
  output logic             fwdA_ID,
  output logic             fwdB_ID,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int MD_W = $clog2(MULDIV_LAT + 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LAT);

  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit, rs_mem_fwd, rt_mem_fwd;
  logic lw_stall, br_stall, md_stall, hazard;

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src_i(rs_EX), .wr_mem_i(writeReg_MEM), .reg_write_mem_i(regWrite_MEM),
    .mem_to_reg_mem_i(memToReg_MEM), .wr_wb_i(writeReg_WB), .reg_write_wb_i(regWrite_WB),
    .sel_o(fwdA_EX)
  );

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src_i(rt_EX), .wr_mem_i(writeReg_MEM), .reg_write_mem_i(regWrite_MEM),
    .mem_to_reg_mem_i(memToReg_MEM), .wr_wb_i(writeReg_WB), .reg_write_wb_i(regWrite_WB),
    .sel_o(fwdB_EX)
  );

  always_comb begin
    rs_ex_hit   = use_rs_ID & (|rs_ID) & (rs_ID == writeReg_EX);
    rt_ex_hit   = use_rt_ID & (|rt_ID) & (rt_ID == writeReg_EX);
    rs_mem_hit  = use_rs_ID & (|rs_ID) & (rs_ID == writeReg_MEM);
    rt_mem_hit  = use_rt_ID & (|rt_ID) & (rt_ID == writeReg_MEM);
    rs_mem_fwd  = (|rs_ID) & (rs_ID == writeReg_MEM);
    rt_mem_fwd  = (|rt_ID) & (rt_ID == writeReg_MEM);
    lw_stall    = memToReg_EX & regWrite_EX & (rs_ex_hit | rt_ex_hit);
    br_stall    = branch_ID & ((regWrite_EX & (rs_ex_hit | rt_ex_hit)) |
                               (memToReg_MEM & (rs_mem_hit | rt_mem_hit)));
    muldiv_busy = md_cnt_q != '0;
    md_stall    = (hilo_rd_ID | muldiv_ID) & muldiv_busy;
    hazard      = lw_stall | br_stall | md_stall;
    pipe_freeze = dmem_req_MEM & ~dmem_ready;
    // A memory wait holds everything, so injecting a bubble would lose the ID instruction.
    IF_ID_stall = pipe_freeze | hazard;
    ID_EX_flush = ~pipe_freeze & hazard;
    fwdA_ID     = regWrite_MEM & ~memToReg_MEM & rs_mem_fwd;
    fwdB_ID     = regWrite_MEM & ~memToReg_MEM & rt_mem_fwd;
    stall_cnt   = stall_cnt_q;
    md_cnt_d    = pipe_freeze ? md_cnt_q :
                  muldiv_EX   ? MD_LOAD :
                  muldiv_busy ? md_cnt_q - MD_W'(1) : md_cnt_q;
    stall_cnt_d = perf_clr ? '0 :
                  (IF_ID_stall & ~(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed literal scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 0, rst_n = 0;
  logic [4:0] rs_ID, rt_ID, rs_EX, rt_EX, writeReg_EX, writeReg_MEM, writeReg_WB;
  logic use_rs_ID, use_rt_ID, branch_ID, hilo_rd_ID, muldiv_ID;
  logic regWrite_EX, memToReg_EX, muldiv_EX, regWrite_MEM, memToReg_MEM;
  logic dmem_req_MEM, dmem_ready, regWrite_WB, perf_clr;
  logic IF_ID_stall, ID_EX_flush, pipe_freeze, fwdA_ID, fwdB_ID, muldiv_busy;
  logic [1:0] fwdA_EX, fwdB_EX;
  logic [CW-1:0] stall_cnt;

  int checks = 0, errors = 0;
  int md_rem = 0, sc = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(5), .MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID),
    .use_rt_ID(use_rt_ID), .branch_ID(branch_ID), .hilo_rd_ID(hilo_rd_ID), .muldiv_ID(muldiv_ID),
    .rs_EX(rs_EX), .rt_EX(rt_EX), .writeReg_EX(writeReg_EX), .regWrite_EX(regWrite_EX),
    .memToReg_EX(memToReg_EX), .muldiv_EX(muldiv_EX), .writeReg_MEM(writeReg_MEM),
    .regWrite_MEM(regWrite_MEM), .memToReg_MEM(memToReg_MEM), .dmem_req_MEM(dmem_req_MEM),
    .dmem_ready(dmem_ready), .writeReg_WB(writeReg_WB), .regWrite_WB(regWrite_WB),
    .perf_clr(perf_clr), .IF_ID_stall(IF_ID_stall), .ID_EX_flush(ID_EX_flush),
    .pipe_freeze(pipe_freeze), .fwdA_EX(fwdA_EX), .fwdB_EX(fwdB_EX), .fwdA_ID(fwdA_ID),
    .fwdB_ID(fwdB_ID), .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m(input logic [4:0] x, input logic [4:0] r);
    return r != 0 && x == r;
  endfunction

  function automatic bit id_hit(input logic [4:0] r);
    return (use_rs_ID && m(rs_ID, r)) || (use_rt_ID && m(rt_ID, r));
  endfunction

  function automatic int exp_fwd(input logic [4:0] s);
    if (regWrite_MEM && !memToReg_MEM && m(s, writeReg_MEM)) return 2;
    if (regWrite_WB && m(s, writeReg_WB)) return 1;
    return 0;
  endfunction

  function automatic bit exp_hazard();
    bit lw, br, md;
    lw = memToReg_EX && regWrite_EX && id_hit(writeReg_EX);
    br = branch_ID && ((regWrite_EX && id_hit(writeReg_EX)) || (memToReg_MEM && id_hit(writeReg_MEM)));
    md = (hilo_rd_ID || muldiv_ID) && md_rem != 0;
    return lw || br || md;
  endfunction

  function automatic bit exp_freeze();
    return dmem_req_MEM && !dmem_ready;
  endfunction

  // Reference state: remaining busy cycles and stall count as plain integers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_rem = 0;
      sc = 0;
    end else begin
      if (perf_clr) sc = 0;
      else if ((exp_freeze() || exp_hazard()) && sc < SAT) sc = sc + 1;
      if (!exp_freeze()) begin
        if (muldiv_EX) md_rem = LAT;
        else if (md_rem > 0) md_rem = md_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("pipe_freeze", pipe_freeze, exp_freeze());
    chk("IF_ID_stall", IF_ID_stall, exp_freeze() || exp_hazard());
    chk("ID_EX_flush", ID_EX_flush, !exp_freeze() && exp_hazard());
    chk("fwdA_EX", fwdA_EX, exp_fwd(rs_EX));
    chk("fwdB_EX", fwdB_EX, exp_fwd(rt_EX));
    chk("fwdA_ID", fwdA_ID, regWrite_MEM && !memToReg_MEM && m(rs_ID, writeReg_MEM));
    chk("fwdB_ID", fwdB_ID, regWrite_MEM && !memToReg_MEM && m(rt_ID, writeReg_MEM));
    chk("muldiv_busy", muldiv_busy, md_rem != 0);
    chk("stall_cnt", stall_cnt, sc);
  end

  task automatic idle();
    {rs_ID, rt_ID, rs_EX, rt_EX, writeReg_EX, writeReg_MEM, writeReg_WB} = '0;
    {use_rs_ID, use_rt_ID, branch_ID, hilo_rd_ID, muldiv_ID} = '0;
    {regWrite_EX, memToReg_EX, muldiv_EX, regWrite_MEM, memToReg_MEM} = '0;
    {dmem_req_MEM, regWrite_WB, perf_clr} = '0;
    dmem_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    #1;
    chk("reset busy", muldiv_busy, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset stall", IF_ID_stall, 0);
    step();
    rst_n = 1;
    // lw $8 in EX, ID reads rt=$8
    memToReg_EX = 1; regWrite_EX = 1; writeReg_EX = 8; rt_ID = 8; use_rt_ID = 1; #1;
    chk("lw stall", IF_ID_stall, 1);
    chk("lw flush", ID_EX_flush, 1);
    step();
    memToReg_MEM = 1; regWrite_MEM = 1; writeReg_MEM = 8; rt_EX = 8; #1;
    chk("lw no MEM fwd", fwdB_EX, 0);
    step();
    regWrite_WB = 1; writeReg_WB = 8; rt_EX = 8; #1;
    chk("lw WB fwd", fwdB_EX, 1);
    step();
    regWrite_MEM = 1; writeReg_MEM = 3; regWrite_WB = 1; writeReg_WB = 4; rs_EX = 3; rt_EX = 4; #1;
    chk("fwdA MEM", fwdA_EX, 2);
    chk("fwdB WB", fwdB_EX, 1);
    writeReg_WB = 3; #1;
    chk("MEM over WB", fwdA_EX, 2);
    rs_EX = 0; writeReg_MEM = 0; writeReg_WB = 0; #1;
    chk("r0 no fwd", fwdA_EX, 0);
    step();
    branch_ID = 1; rs_ID = 5; use_rs_ID = 1; regWrite_EX = 1; writeReg_EX = 5; #1;
    chk("beq EX stall", IF_ID_stall, 1);
    step();
    branch_ID = 1; rs_ID = 5; use_rs_ID = 1; regWrite_MEM = 1; writeReg_MEM = 5; #1;
    chk("beq fwd ID", fwdA_ID, 1);
    chk("beq no stall", IF_ID_stall, 0);
    step();
    branch_ID = 1; rs_ID = 5; use_rs_ID = 1; regWrite_MEM = 1; memToReg_MEM = 1; writeReg_MEM = 5; #1;
    chk("beq lw MEM stall", IF_ID_stall, 1);
    chk("beq lw no ID fwd", fwdA_ID, 0);
    step();
    muldiv_EX = 1;
    for (int k = 0; k < LAT; k++) begin
      step();
      hilo_rd_ID = 1; #1;
      chk("mfhi stall", IF_ID_stall, 1);
    end
    step();
    hilo_rd_ID = 1; #1;
    chk("mfhi released", IF_ID_stall, 0);
    chk("busy dropped", muldiv_busy, 0);
    step();
    perf_clr = 1;
    step();
    muldiv_EX = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      dmem_req_MEM = 1; dmem_ready = 0;
      memToReg_EX = 1; regWrite_EX = 1; writeReg_EX = 7; rs_ID = 7; use_rs_ID = 1; #1;
      chk("freeze", pipe_freeze, 1);
      chk("freeze no flush", ID_EX_flush, 0);
      chk("freeze stall", IF_ID_stall, 1);
      chk("freeze busy", muldiv_busy, 1);
    end
    step(); #1;
    chk("freeze count", stall_cnt, 3);
    for (int k = 0; k < LAT - 1; k++) step();
    #1;
    chk("md held busy", muldiv_busy, 1);
    step(); #1;
    chk("md held done", muldiv_busy, 0);
    muldiv_EX = 1;
    step(); #1;
    chk("busy before reset", muldiv_busy, 1);
    rst_n = 0; #1;
    chk("reset busy async", muldiv_busy, 0);
    step();
    rst_n = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      dmem_req_MEM = 1; dmem_ready = 0;
    end
    step(); #1;
    chk("saturate", stall_cnt, SAT);
    dmem_req_MEM = 1; dmem_ready = 0; perf_clr = 1;
    step(); #1;
    chk("clear wins", stall_cnt, 0);
    for (int k = 0; k < 3000; k++) begin
      step();
      rs_ID = 5'($urandom_range(0, 3)); rt_ID = 5'($urandom_range(0, 3));
      rs_EX = 5'($urandom_range(0, 3)); rt_EX = 5'($urandom_range(0, 3));
      writeReg_EX = 5'($urandom_range(0, 3)); writeReg_MEM = 5'($urandom_range(0, 3));
      writeReg_WB = 5'($urandom_range(0, 3));
      {use_rs_ID, use_rt_ID, branch_ID, regWrite_EX, memToReg_EX, regWrite_MEM, memToReg_MEM, regWrite_WB} = 8'($urandom);
      hilo_rd_ID = $urandom_range(0, 3) == 0;
      muldiv_ID = $urandom_range(0, 5) == 0;
      muldiv_EX = $urandom_range(0, 9) == 0;
      dmem_req_MEM = $urandom_range(0, 1) == 1;
      dmem_ready = $urandom_range(0, 2) != 0;
      perf_clr = $urandom_range(0, 40) == 0;
      rst_n = $urandom_range(0, 150) != 0;
    end
    step();
    rst_n = 1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
